// File: rtl/fpu_add_sched.sv
// Round-robin scheduler sharing one complete_add datapath between two FPU requesters.
// Word format: [31:24] signed exponent, [23:0] two's-complement mantissa; no normalisation.

module complete_add (
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        carry_in,
   output logic [31:0] sum,
   output logic        carry_out,
   output logic        overflow
);
   logic signed [7:0]  exp_a;
   logic signed [7:0]  exp_b;
   logic        [7:0]  exp_big;
   logic        [7:0]  shift_amt;
   logic signed [23:0] man_big;
   logic signed [23:0] man_small;
   logic signed [23:0] man_aligned;
   logic        [24:0] raw_sum;

   // opA is treated as the larger operand when exponents tie
   always_comb begin
      exp_a = op_a[31:24];
      exp_b = op_b[31:24];
      if (exp_a >= exp_b) begin
         exp_big   = op_a[31:24];
         man_big   = op_a[23:0];
         man_small = op_b[23:0];
         shift_amt = op_a[31:24] - op_b[31:24];
      end else begin
         exp_big   = op_b[31:24];
         man_big   = op_b[23:0];
         man_small = op_a[23:0];
         shift_amt = op_b[31:24] - op_a[31:24];
      end
      man_aligned = man_small >>> shift_amt;
      raw_sum     = {1'b0, man_big} + {1'b0, man_aligned} + {24'd0, carry_in};
   end

   assign sum       = {exp_big, raw_sum[23:0]};
   assign carry_out = raw_sum[24];
   assign overflow  = (man_big[23] == man_aligned[23]) && (raw_sum[23] != man_big[23]);
endmodule

module fpu_add_sched #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0]       req_sub,
   input  logic [31:0]      req_opA0,
   input  logic [31:0]      req_opB0,
   input  logic [31:0]      req_opA1,
   input  logic [31:0]      req_opB1,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [31:0]      resp_sum,
   output logic             resp_carry,
   output logic             resp_ovf,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt0,
   output logic [CNT_W-1:0] done_cnt1
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t      state;
   state_t      state_next;
   logic        last_grant;
   logic        grant_id;
   logic        grant_any;
   logic        handshake;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [31:0] op_a_r;
   logic [31:0] op_b_r;
   logic        id_r;
   logic [31:0] add_sum;
   logic        add_carry;
   logic        add_ovf;

   // On a tie the requester that did not win last time gets the slot
   always_comb begin
      grant_id  = 1'b0;
      grant_any = 1'b0;
      case (req_valid)
         2'b01: begin
            grant_id  = 1'b0;
            grant_any = 1'b1;
         end
         2'b10: begin
            grant_id  = 1'b1;
            grant_any = 1'b1;
         end
         2'b11: begin
            grant_id  = ~last_grant;
            grant_any = 1'b1;
         end
         default: begin
            grant_id  = 1'b0;
            grant_any = 1'b0;
         end
      endcase
   end

   assign handshake = (state == IDLE) && grant_any;

   always_comb begin
      req_ready = 2'b00;
      if (handshake && reset_n) begin
         req_ready = grant_id ? 2'b10 : 2'b01;
      end
   end

   // Subtraction folds into the add by negating opB's mantissa at capture time
   always_comb begin
      sel_a = grant_id ? req_opA1 : req_opA0;
      sel_b = grant_id ? req_opB1 : req_opB0;
      if (req_sub[grant_id]) begin
         sel_b[23:0] = ~sel_b[23:0] + 24'd1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (handshake) state_next = EXEC;
         EXEC:    state_next = DONE;
         DONE:    if (resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   complete_add u_add (
      .op_a      (op_a_r),
      .op_b      (op_b_r),
      .carry_in  (1'b0),
      .sum       (add_sum),
      .carry_out (add_carry),
      .overflow  (add_ovf)
   );

   // last_grant resets to 1 so requester 0 wins the first tie
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_a_r     <= 32'd0;
         op_b_r     <= 32'd0;
         id_r       <= 1'b0;
         last_grant <= 1'b1;
         resp_id    <= 1'b0;
         resp_sum   <= 32'd0;
         resp_carry <= 1'b0;
         resp_ovf   <= 1'b0;
         done_cnt0  <= '0;
         done_cnt1  <= '0;
      end else begin
         if (handshake) begin
            op_a_r     <= sel_a;
            op_b_r     <= sel_b;
            id_r       <= grant_id;
            last_grant <= grant_id;
         end
         if (state == EXEC) begin
            resp_id    <= id_r;
            resp_sum   <= add_sum;
            resp_carry <= add_carry;
            resp_ovf   <= add_ovf;
         end
         if ((state == DONE) && resp_ready) begin
            if (id_r) begin
               done_cnt1 <= done_cnt1 + CNT_ONE;
            end else begin
               done_cnt0 <= done_cnt0 + CNT_ONE;
            end
         end
      end
   end

   assign resp_valid = (state == DONE);
   assign busy       = (state != IDLE);
endmodule

// File: doc/fpu_add_sched.md
# fpu_add_sched

Round-robin scheduler that shares one `complete_add` datapath instance between two requesters. Each requester issues an add or subtract of two operands in the FPU word format: bits [31:24] are a signed exponent, bits [23:0] are a signed two's-complement mantissa. The block registers the operands, sequences the adder through a fixed three-state FSM, and returns the tagged result on a single response channel. It sits between the FPU issue logic and the adder, and is the only driver of that adder.

## Interface
Parameters:
- `CNT_W`, default 16: width of the per-requester completion counters.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid[1:0]`  in  2  request valid, one bit per requester i.
- `req_ready[1:0]`  out  2  request accepted; at most one bit set.
- `req_sub[1:0]`  in  2  per requester: 1 = opA − opB, 0 = opA + opB.
- `req_opA0`, `req_opB0`, `req_opA1`, `req_opB1`  in  32 each  operands of requester 0 and 1.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_id`  out  1  requester that owns the result.
- `resp_sum`  out  32  result word.
- `resp_carry`  out  1  mantissa adder carry-out.
- `resp_ovf`  out  1  mantissa adder overflow.
- `busy`  out  1  state ≠ IDLE.
- `done_cnt0`, `done_cnt1`  out  CNT_W each  completed responses per requester; wrap modulo 2^CNT_W.

## Operation
- **FSM states:** IDLE, EXEC, DONE.
- **Grant (combinational, IDLE only):**
  - One `req_valid` set: grant that requester.
  - Both set: grant the requester ≠ `last_grant`.
  - `req_ready[g]` = (state == IDLE) && `req_valid[g]`. `req_ready` may depend combinationally on `req_valid`.
- **IDLE → EXEC** on a handshake. The block captures:
  - `opA_r` = opA of g.
  - `opB_r` = opB of g. If `req_sub`, the mantissa field is replaced by (~m + 1) mod 2^24 and the exponent is unchanged. Negating 0x800000 yields 0x800000 with no flag.
  - `id_r` = g, and `last_grant` ← g.
- **EXEC → DONE** unconditionally. The adder is driven from `opA_r`/`opB_r` with carryin = 0. Its sum, carryout and overflow are captured into the response registers at the end of EXEC.
- **DONE:**
  - `resp_valid` = 1 and the response registers are held stable.
  - On `resp_ready`: `done_cnt[id_r]` increments and the FSM goes to IDLE.
  - Without `resp_ready`: stay in DONE indefinitely.
- **Adder behaviour the bench must model:**
  - Larger = operand with the greater signed exponent; opA wins on equal exponents.
  - Smaller mantissa is arithmetically right-shifted by the exponent difference (low 8 bits).
  - Result = {larger exponent, 24-bit mantissa sum}; no normalisation.
- `req_valid` deasserting before a grant is legal; the request is simply not taken.
- Inputs are ignored outside IDLE.

## Timing
- **Latency:** handshake in cycle t → `resp_valid` = 1 in cycle t+2.
- **Throughput:** one operation per 3 cycles at best. A new `req_ready` can be asserted earliest in cycle t+3, after `resp_ready` in cycle t+2.
- **Reset values** (asynchronous on `reset_n` = 0):
  - State = IDLE.
  - `req_ready` = 0 while in reset; `resp_valid` = 0; `busy` = 0.
  - `resp_id` = 0, `resp_sum` = 0, `resp_carry` = 0, `resp_ovf` = 0.
  - `done_cnt0` = `done_cnt1` = 0.
  - `last_grant` = 1, so requester 0 wins the first tie.
- **Reset mid-operation** (EXEC or DONE): the in-flight operation is discarded, no counter changes, and `resp_valid` drops immediately.
- **Counter wrap:** when `done_cnt` = 2^CNT_W − 1 and a response completes, it returns to 0.
- `resp_*` outputs change only on the EXEC → DONE edge, or on reset.

## Test plan
- **Single add:** requester 0 issues add, opA = 0x04000004, opB = 0x020000FF.
  - Expected: `resp_valid` 2 cycles after the handshake, `resp_sum` = 0x04000043, carry = 0, ovf = 0, `resp_id` = 0, `done_cnt0` = 1.
- **Subtract:** requester 1 issues sub, opA = 0x04000004, opB = 0x02000008.
  - Expected: `resp_sum` = 0x04000002, carry = 1, ovf = 0, `resp_id` = 1.
- **Equal exponents:** add 0x01000001 + 0x01000002.
  - Expected: `resp_sum` = 0x01000003.
- **Arbitration:** both requesters hold `req_valid` continuously with `resp_ready` = 1.
  - Expected: grants alternate 0, 1, 0, 1 starting with 0; one handshake every 3 cycles.
- **Backpressure:** hold `resp_ready` = 0 for 5 cycles in DONE.
  - Expected: `resp_*` stable, `req_ready` = 00, `busy` = 1, no counter change. Then `resp_ready` = 1 → IDLE on the next cycle.
- **Reset mid-EXEC:** assert `reset_n` = 0 in EXEC.
  - Expected: all outputs at reset values. After release, a new request is handled normally, with requester 0 winning a tie.
